// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of two register-file write ports between NREQ requesters
module regfile_write_arbiter #(
    parameter int NREQ       = 4,
    parameter int ADDR_BITS  = 5,
    parameter int DATA_BITS  = 32,
    parameter int ZERO_GUARD = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*ADDR_BITS-1:0] req_addr,
    input  logic [NREQ*DATA_BITS-1:0] req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      wen0,
    output logic [ADDR_BITS-1:0]      waddr0,
    output logic [DATA_BITS-1:0]      wdata0,
    output logic                      wen1,
    output logic [ADDR_BITS-1:0]      waddr1,
    output logic [DATA_BITS-1:0]      wdata1,
    output logic [15:0]               conflict_cnt
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [ADDR_BITS-1:0] addr [NREQ];
    logic [DATA_BITS-1:0] data [NREQ];
    logic [PW-1:0]        rr_ptr, g0, g1, idx, last, nxt_ptr;
    logic [PW:0]          sum;
    logic [ADDR_BITS-1:0] a0;
    logic                 found0, found1, deferred, z0, z1;

    // unpack the flat request buses into per-requester slices
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr[i] = req_addr[i*ADDR_BITS +: ADDR_BITS];
            data[i] = req_data[i*DATA_BITS +: DATA_BITS];
        end
    end

    // scan from rr_ptr: first valid takes port 0, next valid with a different address takes port 1
    always_comb begin
        found0    = 1'b0;
        found1    = 1'b0;
        deferred  = 1'b0;
        g0        = '0;
        g1        = '0;
        a0        = '0;
        sum       = '0;
        idx       = '0;
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(k);
            idx = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ)) : PW'(sum);
            if (req_valid[idx]) begin
                if (!found0) begin
                    found0 = 1'b1;
                    g0     = idx;
                    a0     = addr[idx];
                end else if (!found1) begin
                    if (addr[idx] != a0) begin
                        found1 = 1'b1;
                        g1     = idx;
                    end else begin
                        deferred = 1'b1;
                    end
                end
            end
        end
        if (found0) req_ready[g0] = 1'b1;
        if (found1) req_ready[g1] = 1'b1;
    end

    // pointer advances past the last granted requester; register 0 writes are swallowed when guarded
    always_comb begin
        last    = found1 ? g1 : g0;
        nxt_ptr = (last == PW'(NREQ-1)) ? '0 : last + 1'b1;
        z0      = (ZERO_GUARD != 0) && (a0 == '0);
        z1      = (ZERO_GUARD != 0) && (addr[g1] == '0);
    end

    // register the granted writes, the round-robin pointer and the conflict counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen0         <= 1'b0;
            waddr0       <= '0;
            wdata0       <= '0;
            wen1         <= 1'b0;
            waddr1       <= '0;
            wdata1       <= '0;
            conflict_cnt <= '0;
            rr_ptr       <= '0;
        end else begin
            wen0 <= found0 && !z0;
            wen1 <= found1 && !z1;
            if (found0) begin
                waddr0 <= a0;
                wdata0 <= data[g0];
                rr_ptr <= nxt_ptr;
            end
            if (found1) begin
                waddr1 <= addr[g1];
                wdata1 <= data[g1];
            end
            if (deferred && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed vectors with a write scoreboard checked by a separate monitor
module tb_regfile_write_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [19:0] req_addr;
    logic [127:0] req_data;
    logic [3:0]  req_ready;
    logic        wen0, wen1;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wdata0, wdata1;
    logic [15:0] conflict_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        port;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t q[$];

    logic [4:0]  ta [4];
    logic [31:0] td [4];

    regfile_write_arbiter #(.NREQ(4), .ADDR_BITS(5), .DATA_BITS(32), .ZERO_GUARD(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    task automatic push(input logic port, input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.port = port;
        e.a = a;
        e.d = d;
        q.push_back(e);
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] er);
        req_valid = v;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*5 +: 5] = ta[i];
            req_data[i*32 +: 32] = td[i];
        end
        #1;
        chk("ready", 64'(req_ready), 64'(er));
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        ta[i] = a;
        td[i] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pop_cmp(input logic port, input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write actual=port%0d addr=%0d data=%h required=no write", port, a, d);
        end else begin
            e = q.pop_front();
            if ({port, a, d} !== {e.port, e.a, e.d}) begin
                failures++;
                $display("FAIL write actual=port%0d addr=%0d data=%h required=port%0d addr=%0d data=%h",
                         port, a, d, e.port, e.a, e.d);
            end
        end
    endtask

    // monitor: every write the DUT presents must match the head of the scoreboard
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (wen0) pop_cmp(1'b0, waddr0, wdata0);
                if (wen1) pop_cmp(1'b1, waddr1, wdata1);
                if (wen0 && wen1) chk("distinct_addr", 64'(waddr0 != waddr1), 64'd1);
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) set_req(i, 5'(i + 11), 32'h1000 + 32'(i));
        rst = 1'b1;
        drive(4'b1111, 4'b0011);
        chk("rst_wen", 64'({wen0, wen1}), 64'd0);
        chk("rst_addr", 64'({waddr0, waddr1}), 64'd0);
        chk("rst_data", {wdata0, wdata1}, 64'd0);
        chk("rst_cnt", 64'(conflict_cnt), 64'd0);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_wen", 64'({wen0, wen1}), 64'd0);
        chk("idle_cnt", 64'(conflict_cnt), 64'd0);
        chk("idle_ready", 64'(req_ready), 64'd0);

        // two distinct writes
        set_req(0, 5'd3, 32'hAAAA0001);
        set_req(2, 5'd7, 32'hBBBB0002);
        drive(4'b0101, 4'b0101);
        push(1'b0, 5'd3, 32'hAAAA0001);
        push(1'b1, 5'd7, 32'hBBBB0002);
        @(negedge clk);
        chk("rr_after_pair", 64'(dut.rr_ptr), 64'd3);
        req_valid = '0;

        // same-address conflict
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 5'd9, 32'hC000 + 32'(i));
        drive(4'b1011, 4'b0001);
        push(1'b0, 5'd9, 32'hC000);
        @(negedge clk);
        chk("cnt_conflict1", 64'(conflict_cnt), 64'd1);
        drive(4'b1010, 4'b0010);
        push(1'b0, 5'd9, 32'hC001);
        @(negedge clk);
        drive(4'b1000, 4'b1000);
        push(1'b0, 5'd9, 32'hC003);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        chk("cnt_conflict2", 64'(conflict_cnt), 64'd2);

        // fairness with four distinct addresses
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 5'(i + 1), 32'hF000 + 32'(i));
        for (int c = 0; c < 4; c++) begin
            drive(4'b1111, (c % 2 == 0) ? 4'b0011 : 4'b1100);
            push(1'b0, 5'(2*(c%2) + 1), 32'hF000 + 32'(2*(c%2)));
            push(1'b1, 5'(2*(c%2) + 2), 32'hF001 + 32'(2*(c%2)));
            @(negedge clk);
        end
        req_valid = '0;
        chk("rr_after_fair", 64'(dut.rr_ptr), 64'd0);
        chk("cnt_fair", 64'(conflict_cnt), 64'd0);

        // zero guard: register 0 grant is absorbed
        set_req(1, 5'd0, 32'h2E201);
        set_req(2, 5'd4, 32'h2E202);
        drive(4'b0110, 4'b0110);
        push(1'b1, 5'd4, 32'h2E202);
        @(negedge clk);
        req_valid = '0;
        chk("zg_wen", 64'({wen0, wen1}), 64'b01);
        chk("zg_rr", 64'(dut.rr_ptr), 64'd3);

        // reset arriving while a grant is being issued
        set_req(0, 5'd5, 32'hD0);
        set_req(1, 5'd5, 32'hD1);
        drive(4'b0011, 4'b0001);
        push(1'b0, 5'd5, 32'hD0);
        @(negedge clk);
        chk("cnt_pre_rst", 64'(conflict_cnt), 64'd1);
        drive(4'b0010, 4'b0010);
        #2;
        rst = 1'b1;
        @(negedge clk);
        req_valid = '0;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_wen", 64'({wen0, wen1}), 64'd0);
        chk("midrst_rr", 64'(dut.rr_ptr), 64'd0);
        chk("midrst_cnt", 64'(conflict_cnt), 64'd0);
        repeat (2) @(negedge clk);
        chk("sb_empty", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
